hp_ramp_ctrl: RTL and testbench



---
 rtl/hp_ramp_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_hp_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hp_ramp_ctrl
//  Description : Ramp scheduler for the clk_en_sig half-period register.
//                Steps the generator half period from a start value to a
//                target value in fixed increments, one step every N enable
//                pulses, giving a linear accel/decel frequency ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
module hp_ramp_ctrl #(
  parameter int              HP_W    = 22,
  parameter int              PPS_W   = 16,
  parameter logic [HP_W-1:0] PARK_HP = 22'd125000,
  parameter logic [HP_W-1:0] MIN_HP  = 22'd2
) (
  input  logic              s_axi_aclk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [HP_W-1:0]   i_start_hp,
  input  logic [HP_W-1:0]   i_target_hp,
  input  logic [HP_W-1:0]   i_step,
  input  logic [PPS_W-1:0]  i_pulses_per_step,
  input  logic              i_clk_en,
  output logic [HP_W-1:0]   o_half_period,
  output logic              o_write_hp,
  output logic              o_busy,
  output logic              o_at_target,
  output logic              o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [HP_W-1:0]  cur_hp_q, cur_hp_d;
  logic [HP_W-1:0]  target_q, target_d;
  logic [HP_W-1:0]  step_q, step_d;
  logic [PPS_W-1:0] pps_q, pps_d;
  logic [PPS_W-1:0] cnt_q, cnt_d;
  // park_q marks that the WRITE in progress is the abort park write, which
  // must return to IDLE rather than continue the ramp.
  logic             park_q, park_d;
  // An abort that lands on a WRITE cycle is deferred by one cycle so the
  // park strobe is still separated from the previous strobe by a low cycle.
  logic             abort_pend_q, abort_pend_d;
  logic [HP_W-1:0]  half_period_q, half_period_d;
  logic             write_hp_q, write_hp_d;
  logic             done_q, done_d;

  // --------------------------------------------------------------------------
  // Input conditioning for a new ramp
  // --------------------------------------------------------------------------
  logic [HP_W-1:0]  start_hp_clamped;
  logic [HP_W-1:0]  target_clamped;
  logic [PPS_W-1:0] pps_in;

  // Targets below the floor are raised to it so the ramp can always land
  // exactly on its (effective) target.
  assign start_hp_clamped = (i_start_hp  < MIN_HP) ? MIN_HP : i_start_hp;
  assign target_clamped   = (i_target_hp < MIN_HP) ? MIN_HP : i_target_hp;
  assign pps_in           = (i_pulses_per_step == '0) ? PPS_W'(1) : i_pulses_per_step;

  // --------------------------------------------------------------------------
  // Next half period, computed with one extra bit to catch borrow/carry
  // --------------------------------------------------------------------------
  logic [HP_W:0]   diff_ext;
  logic [HP_W:0]   sum_ext;
  logic [HP_W:0]   tgt_ext;
  logic [HP_W-1:0] next_raw;
  logic [HP_W-1:0] next_hp;
  logic [PPS_W-1:0] cnt_inc;

  assign diff_ext = {1'b0, cur_hp_q} - {1'b0, step_q};
  assign sum_ext  = {1'b0, cur_hp_q} + {1'b0, step_q};
  assign tgt_ext  = {1'b0, target_q};
  assign cnt_inc  = cnt_q + PPS_W'(1);

  // Step toward the target, never overshooting it in either direction.
  always_comb begin
    next_raw = target_q;
    if (target_q < cur_hp_q) begin
      if (diff_ext[HP_W] || (diff_ext < tgt_ext)) begin
        next_raw = target_q;
      end else begin
        next_raw = diff_ext[HP_W-1:0];
      end
    end else begin
      if (sum_ext > tgt_ext) begin
        next_raw = target_q;
      end else begin
        next_raw = sum_ext[HP_W-1:0];
      end
    end
  end

  assign next_hp = (next_raw < MIN_HP) ? MIN_HP : next_raw;

  // --------------------------------------------------------------------------
  // Next-state logic and registered output preparation
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cur_hp_d      = cur_hp_q;
    target_d      = target_q;
    step_d        = step_q;
    pps_d         = pps_q;
    cnt_d         = cnt_q;
    park_d        = park_q;
    abort_pend_d  = abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          target_d     = target_clamped;
          step_d       = i_step;
          pps_d        = pps_in;
          cur_hp_d     = (i_step == '0) ? target_clamped : start_hp_clamped;
          park_d       = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = ST_WRITE;
        end
      end

      ST_WRITE: begin
        cnt_d = '0;
        if (park_q) begin
          park_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (i_abort) begin
          abort_pend_d = 1'b1;
          state_d      = ST_WAIT;
        end else if ((cur_hp_q == target_q) || (step_q == '0)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (i_abort || abort_pend_q) begin
          cur_hp_d     = PARK_HP;
          park_d       = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = ST_WRITE;
        end else if (i_clk_en) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pps_q) begin
            cur_hp_d = next_hp;
            state_d  = ST_WRITE;
          end
        end
      end

      ST_HOLD: begin
        if (i_abort) begin
          cur_hp_d = PARK_HP;
          park_d   = 1'b1;
          state_d  = ST_WRITE;
        end else if (i_start) begin
          target_d = target_clamped;
          step_d   = i_step;
          pps_d    = pps_in;
          cur_hp_d = (i_step == '0) ? target_clamped : start_hp_clamped;
          park_d   = 1'b0;
          state_d  = ST_WRITE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered so the strobe and value line up with WRITE.
  always_comb begin
    write_hp_d    = (state_d == ST_WRITE);
    half_period_d = (state_d == ST_WRITE) ? cur_hp_d : half_period_q;
    done_d        = (state_d == ST_HOLD) && (state_q != ST_HOLD);
  end

  // State and output registers with synchronous reset to the parked state.
  always_ff @(posedge s_axi_aclk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      cur_hp_q      <= PARK_HP;
      target_q      <= PARK_HP;
      step_q        <= '0;
      pps_q         <= PPS_W'(1);
      cnt_q         <= '0;
      park_q        <= 1'b0;
      abort_pend_q  <= 1'b0;
      half_period_q <= PARK_HP;
      write_hp_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_hp_q      <= cur_hp_d;
      target_q      <= target_d;
      step_q        <= step_d;
      pps_q         <= pps_d;
      cnt_q         <= cnt_d;
      park_q        <= park_d;
      abort_pend_q  <= abort_pend_d;
      half_period_q <= half_period_d;
      write_hp_q    <= write_hp_d;
      done_q        <= done_d;
    end
  end

  assign o_half_period = half_period_q;
  assign o_write_hp    = write_hp_q;
  assign o_done        = done_q;
  assign o_busy        = (state_q == ST_WRITE) || (state_q == ST_WAIT);
  assign o_at_target   = (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_hp_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hp_ramp_ctrl
//  Description : Directed self-checking bench for hp_ramp_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hp_ramp_ctrl;

  localparam int HP_W  = 22;
  localparam int PPS_W = 16;
  localparam logic [HP_W-1:0] PARK = 22'd125000;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [HP_W-1:0]   i_start_hp = '0;
  logic [HP_W-1:0]   i_target_hp = '0;
  logic [HP_W-1:0]   i_step = '0;
  logic [PPS_W-1:0]  i_pulses_per_step = '0;
  logic              i_clk_en = 1'b0;
  logic [HP_W-1:0]   o_half_period;
  logic              o_write_hp;
  logic              o_busy;
  logic              o_at_target;
  logic              o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [HP_W-1:0] wr_q[$];
  int              en_q[$];
  int              en_cnt   = 0;
  int              done_cnt = 0;
  logic            prev_wr  = 1'b0;
  int              en_mode  = 0;
  int              en_cyc   = 0;

  always #5 clk = ~clk;

  hp_ramp_ctrl dut (
    .s_axi_aclk        (clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_start_hp        (i_start_hp),
    .i_target_hp       (i_target_hp),
    .i_step            (i_step),
    .i_pulses_per_step (i_pulses_per_step),
    .i_clk_en          (i_clk_en),
    .o_half_period     (o_half_period),
    .o_write_hp        (o_write_hp),
    .o_busy            (o_busy),
    .o_at_target       (o_at_target),
    .o_done            (o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: logs each write, counts enables seen in WAIT, checks spacing.
  initial begin
    forever begin
      @(negedge clk);
      if (o_write_hp === 1'b1) begin
        check("strobe_spacing", {31'd0, prev_wr}, 32'd0);
        wr_q.push_back(o_half_period);
        en_q.push_back(en_cnt);
        en_cnt = 0;
      end else if (o_busy === 1'b1 && i_clk_en) begin
        en_cnt++;
      end
      prev_wr = (o_write_hp === 1'b1);
      if (o_done === 1'b1) done_cnt++;
    end
  end

  // Enable-pulse source: 0 = off, 1 = every third cycle, 2 = continuous.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      en_cyc++;
      case (en_mode)
        0:       i_clk_en = 1'b0;
        1:       i_clk_en = (en_cyc % 3 == 0);
        default: i_clk_en = 1'b1;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_ramp(input int s, input int t, input int st, input int p);
    wr_q.delete();
    en_q.delete();
    en_cnt   = 0;
    done_cnt = 0;
    i_start_hp        = HP_W'(s);
    i_target_hp       = HP_W'(t);
    i_step            = HP_W'(st);
    i_pulses_per_step = PPS_W'(p);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_target(input string tag);
    int k;
    k = 0;
    while (o_at_target !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    check({tag, "_reached"}, {31'd0, (k < 500)}, 32'd1);
    tick(2);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input int e0, input int e1, input int e2, input int e3,
                              input int pps);
    int e[4];
    e = '{e0, e1, e2, e3};
    check({tag, "_nwrites"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check($sformatf("%s_wr%0d", tag, i), {10'd0, wr_q[i]}, e[i]);
      if (i > 0) check($sformatf("%s_pulses%0d", tag, i), en_q[i], pps);
    end
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_at_target"}, {31'd0, o_at_target}, 32'd1);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_half_period", {10'd0, o_half_period}, PARK);
    check("rst_write_hp", {31'd0, o_write_hp}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_at_target", {31'd0, o_at_target}, 0);
    check("rst_done", {31'd0, o_done}, 0);
    i_reset = 1'b0;
    tick(1);

    // Accel ramp; strobe appears the cycle after start
    en_mode = 1;
    start_ramp(100, 70, 10, 2);
    check("t1_first_strobe", {31'd0, o_write_hp}, 1);
    check("t1_first_value", {10'd0, o_half_period}, 100);
    check("t1_busy", {31'd0, o_busy}, 1);
    wait_target("t1");
    check_writes("t1", 4, 100, 90, 80, 70, 2);

    // Decel with clamp to target, and accel with underflow past target
    start_ramp(50, 75, 20, 1);
    wait_target("t2a");
    check_writes("t2a", 3, 50, 70, 75, 0, 1);
    start_ramp(10, 3, 8, 1);
    wait_target("t2b");
    check_writes("t2b", 2, 10, 3, 0, 0, 1);

    // step=0, pps=0, start below floor
    start_ramp(40, 60, 0, 1);
    wait_target("t3a");
    check_writes("t3a", 1, 60, 0, 0, 0, 1);
    start_ramp(30, 10, 10, 0);
    wait_target("t3b");
    check_writes("t3b", 3, 30, 20, 10, 0, 1);
    start_ramp(1, 5, 2, 1);
    wait_target("t3c");
    check_writes("t3c", 3, 2, 4, 5, 0, 1);

    // Continuous enables: spacing enforced, WRITE-cycle enable not counted
    en_mode = 2;
    start_ramp(100, 70, 10, 1);
    wait_target("t5");
    check_writes("t5", 4, 100, 90, 80, 70, 1);

    // Abort during WAIT
    en_mode = 0;
    tick(2);
    start_ramp(100, 70, 10, 2);
    tick(3);
    check("t4_busy_wait", {31'd0, o_busy}, 1);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("t4_park_strobe", {31'd0, o_write_hp}, 1);
    check("t4_park_value", {10'd0, o_half_period}, PARK);
    tick(1);
    check("t4_idle_busy", {31'd0, o_busy}, 0);
    check("t4_idle_at_target", {31'd0, o_at_target}, 0);
    tick(5);
    check("t4_no_done", done_cnt, 0);
    check("t4_nwrites", wr_q.size(), 2);

    // Reset mid-ramp: no park write
    start_ramp(100, 70, 10, 2);
    tick(3);
    i_reset = 1'b1;
    tick(1);
    check("t6_rst_half_period", {10'd0, o_half_period}, PARK);
    check("t6_rst_write", {31'd0, o_write_hp}, 0);
    check("t6_rst_busy", {31'd0, o_busy}, 0);
    i_reset = 1'b0;
    tick(3);
    check("t6_rst_nwrites", wr_q.size(), 1);

    // Start and abort together while busy: abort wins, no restart
    start_ramp(100, 70, 10, 2);
    tick(3);
    i_start = 1'b1;
    i_abort = 1'b1;
    tick(1);
    i_start = 1'b0;
    i_abort = 1'b0;
    check("t6_prio_strobe", {31'd0, o_write_hp}, 1);
    check("t6_prio_value", {10'd0, o_half_period}, PARK);
    tick(1);
    check("t6_prio_idle", {31'd0, o_busy}, 0);
    tick(5);
    check("t6_prio_nwrites", wr_q.size(), 2);
    check("t6_prio_still_idle", {31'd0, o_busy}, 0);
    check("t6_prio_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
